// File: rtl/sram_be_init.sv
// sram_be_init: dual-port byte-enable block RAM with write-first forwarding, 1/2-cycle read latency and a fill-on-reset init engine.
// Ports: clk/rst (async, active-high); init_req restarts the fill; ready marks the array usable;
// wr_en/wr_addr/wr_be/din write port; rd_en/rd_addr read port; dout/dout_vld qualified read data;
// wr_drop_cnt saturating count of writes ignored while not ready or out of range.
module sram_be_init #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int DEPTH = 2**ADDR_W,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_req,
  output logic                ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   din,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_vld,
  output logic [7:0]          wr_drop_cnt
);
  localparam int NB = DATA_W / 8;
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [MW-1:0] LAST = MW'(DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state;
  logic [MW-1:0] r_cnt;
  logic r_ready;
  logic [7:0] r_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_pipe;
  logic r_pipe_vld;
  logic w_wr_in, w_rd_in, w_wr, w_rd, w_drop;
  logic [DATA_W-1:0] w_stored, w_rd_word;
  assign w_wr_in = {1'b0, wr_addr} < DEPTH_X;
  assign w_rd_in = {1'b0, rd_addr} < DEPTH_X;
  assign w_wr = r_ready && wr_en && w_wr_in;
  assign w_rd = r_ready && rd_en;
  assign w_drop = wr_en && !(r_ready && w_wr_in);
  assign w_stored = w_rd_in ? r_mem[rd_addr[MW-1:0]] : '0;
  assign ready = r_ready;
  assign wr_drop_cnt = r_drop;
  // Write-first: bytes being written this cycle to the read address bypass the array.
  always_comb begin
    w_rd_word = w_stored;
    for (int i = 0; i < NB; i++)
      if (w_wr && wr_addr == rd_addr && wr_be[i]) w_rd_word[8*i+:8] = din[8*i+:8];
  end
  always_ff @(posedge clk) begin
    if (r_state == INIT) r_mem[r_cnt] <= INIT_VAL;
    else if (w_wr)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) r_mem[wr_addr[MW-1:0]][8*i+:8] <= din[8*i+:8];
  end
  // ready lags the INIT->RUN transition by one edge and drops on the edge that samples init_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_drop <= '0;
    end else begin
      r_ready <= r_state == RUN && !init_req;
      r_drop <= r_drop + 8'(w_drop && r_drop != 8'hFF);
      if (init_req) begin
        r_state <= INIT;
        r_cnt <= '0;
      end else if (r_state == INIT) begin
        r_state <= r_cnt == LAST ? RUN : INIT;
        r_cnt <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
      end
    end
  end
  // First read stage captures the merged word, so later writes cannot disturb an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
      r_pipe_vld <= 1'b0;
    end else begin
      r_pipe_vld <= w_rd;
      if (w_rd) r_pipe <= w_rd_word;
    end
  end
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_dout;
    logic r_vld;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout <= '0;
        r_vld <= 1'b0;
      end else begin
        r_vld <= r_pipe_vld;
        if (r_pipe_vld) r_dout <= r_pipe;
      end
    end
    assign dout = r_dout;
    assign dout_vld = r_vld;
  end else begin : g_lat1
    assign dout = r_pipe;
    assign dout_vld = r_pipe_vld;
  end
endmodule

// File: tb/tb_sram_be_init.sv
// tb_sram_be_init: scoreboard bench driving RD_LAT=1 and RD_LAT=2 instances of sram_be_init in lockstep.
module tb_sram_be_init;
  localparam int AW = 5;
  localparam int D = 16;
  localparam logic [15:0] IV = 16'hA5A5;
  logic clk = 0, rst = 1, init_req = 0, wr_en = 0, rd_en = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [1:0] wr_be = '0;
  logic [15:0] din = '0;
  logic ready1, vld1, ready2, vld2;
  logic [15:0] dout1, dout2, last1 = '0, last2 = '0;
  logic [7:0] drop1, drop2;
  typedef struct {logic [15:0] d; int due;} item_t;
  item_t q1[$], q2[$];
  int n_cmp = 0, n_err = 0, cyc = 0, exp_drop = 0;
  logic m_ready = 0;
  logic [15:0] m_mem [D];

  sram_be_init #(.DATA_W(16), .ADDR_W(AW), .DEPTH(D), .RD_LAT(1), .INIT_VAL(IV)) u_lat1 (
    .clk(clk), .rst(rst), .init_req(init_req), .ready(ready1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout1), .dout_vld(vld1),
    .wr_drop_cnt(drop1));
  sram_be_init #(.DATA_W(16), .ADDR_W(AW), .DEPTH(D), .RD_LAT(2), .INIT_VAL(IV)) u_lat2 (
    .clk(clk), .rst(rst), .init_req(init_req), .ready(ready2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout2), .dout_vld(vld2),
    .wr_drop_cnt(drop2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    item_t it;
    if (rst) last1 = '0;
    else if (vld1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL lat1_unexpected_vld: dout=%h with no read outstanding", dout1);
      end else begin
        it = q1.pop_front();
        if (dout1 !== it.d || cyc != it.due) begin
          n_err++;
          $display("FAIL lat1_read: got %h at cycle %0d, expected %h at cycle %0d", dout1, cyc, it.d, it.due);
        end
      end
      last1 = dout1;
    end else begin
      n_cmp++;
      if (dout1 !== last1) begin
        n_err++;
        $display("FAIL lat1_hold: dout=%h while idle, expected held %h", dout1, last1);
      end
    end
  end

  always @(negedge clk) begin
    item_t it;
    if (rst) last2 = '0;
    else if (vld2) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL lat2_unexpected_vld: dout=%h with no read outstanding", dout2);
      end else begin
        it = q2.pop_front();
        if (dout2 !== it.d || cyc != it.due) begin
          n_err++;
          $display("FAIL lat2_read: got %h at cycle %0d, expected %h at cycle %0d", dout2, cyc, it.d, it.due);
        end
      end
      last2 = dout2;
    end else begin
      n_cmp++;
      if (dout2 !== last2) begin
        n_err++;
        $display("FAIL lat2_hold: dout=%h while idle, expected held %h", dout2, last2);
      end
    end
  end

  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [1:0] be, input logic [15:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic ir);
    logic [15:0] e;
    wr_en = we; wr_addr = wa; wr_be = be; din = d; rd_en = re; rd_addr = ra; init_req = ir;
    if (m_ready && re) begin
      e = ra < AW'(D) ? m_mem[ra[3:0]] : 16'h0000;
      if (we && wa == ra && wa < AW'(D))
        for (int b = 0; b < 2; b++) if (be[b]) e[8*b+:8] = d[8*b+:8];
      q1.push_back('{e, cyc + 1});
      q2.push_back('{e, cyc + 2});
    end
    if (we) begin
      if (m_ready && wa < AW'(D)) begin
        for (int b = 0; b < 2; b++) if (be[b]) m_mem[wa[3:0]][8*b+:8] = d[8*b+:8];
      end else if (exp_drop < 255) exp_drop++;
    end
    if (ir) begin
      m_ready = 0;
      foreach (m_mem[j]) m_mem[j] = IV;
    end
    @(negedge clk);
    wr_en = 0; rd_en = 0; init_req = 0; wr_be = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, '0, 0);
  endtask

  task automatic test_reset;
    foreach (m_mem[j]) m_mem[j] = IV;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready1, vld1, dout1, drop1, ready2, vld2, dout2, drop2} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b/%b vld=%b/%b dout=%h/%h drop=%0d/%0d, expected all zero",
               ready1, ready2, vld1, vld2, dout1, dout2, drop1, drop2);
    end
    rst = 0;
    for (int i = 1; i <= 17; i++) begin
      cycle(i % 4 == 2, AW'(i), 2'b11, 16'hDEAD, i == 9, AW'(i), 0);
      n_cmp++;
      if (ready1 !== (i == 17) || ready2 !== (i == 17)) begin
        n_err++;
        $display("FAIL ready_rise: edge %0d ready=%b/%b, expected %b", i, ready1, ready2, i == 17);
      end
    end
    m_ready = 1;
    n_cmp++;
    if (drop1 !== 8'(exp_drop) || drop2 !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL init_drops: wr_drop_cnt=%0d/%0d, expected %0d", drop1, drop2, exp_drop);
    end
    for (int i = 0; i < D; i++) cycle(0, '0, '0, '0, 1, AW'(i), 0);
    idle(3);
  endtask

  task automatic test_byte_enable;
    cycle(1, 5'd3, 2'b11, 16'h1234, 0, '0, 0);
    cycle(1, 5'd3, 2'b01, 16'hFFFF, 0, '0, 0);
    cycle(1, 5'd3, 2'b00, 16'h0000, 0, '0, 0);
    cycle(0, '0, '0, '0, 1, 5'd3, 0);
    n_cmp++;
    if (vld1 !== 1'b1 || dout1 !== 16'h12FF || drop1 !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL byte_enable: vld=%b dout=%h drop=%0d, expected vld=1 dout=12ff drop=%0d", vld1, dout1, drop1, exp_drop);
    end
    idle(2);
  endtask

  task automatic test_collision;
    cycle(1, 5'd7, 2'b11, 16'h1111, 0, '0, 0);
    cycle(1, 5'd7, 2'b10, 16'hABCD, 1, 5'd7, 0);
    n_cmp++;
    if (vld1 !== 1'b1 || dout1 !== 16'hAB11) begin
      n_err++;
      $display("FAIL collision: vld=%b dout=%h, expected vld=1 dout=ab11", vld1, dout1);
    end
    cycle(0, '0, '0, '0, 1, 5'd7, 0);
    cycle(1, 5'd7, 2'b11, 16'h0F0F, 0, '0, 0);
    idle(2);
  endtask

  task automatic test_stream;
    int first, cnt;
    first = -1; cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1, AW'(i), 2'b11, 16'h5A00 ^ (16'h0101 * 16'(i)), 0, '0, 0);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) cycle(0, '0, '0, '0, 1, AW'(k), 0);
      else idle(1);
      if (vld2) begin
        if (first < 0) first = k;
        cnt++;
      end
    end
    n_cmp++;
    if (first != 1 || cnt != 8) begin
      n_err++;
      $display("FAIL stream_lat2: first pulse after read %0d with %0d pulses, expected 1 and 8", first, cnt);
    end
  endtask

  task automatic test_drops;
    cycle(1, 5'd20, 2'b11, 16'hBEEF, 1, 5'd20, 0);
    n_cmp++;
    if (drop1 !== 8'(exp_drop) || drop2 !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL oob_drop: wr_drop_cnt=%0d/%0d, expected %0d", drop1, drop2, exp_drop);
    end
    for (int i = 0; i < 300; i++) cycle(1, AW'(16 + i % 16), 2'b11, 16'(i), 0, '0, 0);
    n_cmp++;
    if (drop1 !== 8'd255 || drop2 !== 8'd255) begin
      n_err++;
      $display("FAIL drop_saturate: wr_drop_cnt=%0d/%0d, expected 255", drop1, drop2);
    end
    idle(2);
  endtask

  task automatic test_reinit;
    cycle(1, 5'd5, 2'b11, 16'h0000, 0, '0, 0);
    cycle(0, '0, '0, '0, 1, 5'd5, 1);
    n_cmp++;
    if (ready1 !== 1'b0 || ready2 !== 1'b0 || vld1 !== 1'b1 || dout1 !== 16'h0000) begin
      n_err++;
      $display("FAIL init_req: ready=%b/%b vld=%b dout=%h, expected ready=0 vld=1 dout=0000", ready1, ready2, vld1, dout1);
    end
    idle(4);
    cycle(1, 5'd2, 2'b11, 16'h7777, 1, 5'd2, 1);
    for (int i = 1; i <= 17; i++) begin
      idle(1);
      n_cmp++;
      if (ready1 !== (i == 17) || ready2 !== (i == 17)) begin
        n_err++;
        $display("FAIL reinit_ready: edge %0d after restart ready=%b/%b, expected %b", i, ready1, ready2, i == 17);
      end
    end
    m_ready = 1;
    n_cmp++;
    if (drop1 !== 8'd255 || drop2 !== 8'd255) begin
      n_err++;
      $display("FAIL drop_kept: wr_drop_cnt=%0d/%0d after re-init, expected 255", drop1, drop2);
    end
    cycle(0, '0, '0, '0, 1, 5'd5, 0);
    n_cmp++;
    if (vld1 !== 1'b1 || dout1 !== IV) begin
      n_err++;
      $display("FAIL reinit_value: vld=%b dout=%h, expected vld=1 dout=%h", vld1, dout1, IV);
    end
    cycle(0, '0, '0, '0, 1, 5'd0, 0);
    idle(3);
  endtask

  task automatic test_async_reset;
    cycle(0, '0, '0, '0, 1, 5'd2, 0);
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({ready1, vld1, dout1, drop1, ready2, vld2, dout2, drop2} !== '0) begin
      n_err++;
      $display("FAIL async_reset_read: ready=%b/%b vld=%b/%b dout=%h/%h drop=%0d/%0d, expected all zero",
               ready1, ready2, vld1, vld2, dout1, dout2, drop1, drop2);
    end
    q1.delete(); q2.delete();
    m_ready = 0; exp_drop = 0;
    foreach (m_mem[j]) m_mem[j] = IV;
    repeat (2) @(negedge clk);
    rst = 0;
    idle(5);
    #2 rst = 1;
    #1;
    n_cmp++;
    if (ready1 !== 1'b0 || ready2 !== 1'b0 || drop1 !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset_init: ready=%b/%b drop=%0d, expected 0", ready1, ready2, drop1);
    end
    @(negedge clk);
    rst = 0;
    for (int i = 1; i <= 17; i++) begin
      idle(1);
      n_cmp++;
      if (ready1 !== (i == 17) || ready2 !== (i == 17)) begin
        n_err++;
        $display("FAIL refill_ready: edge %0d ready=%b/%b, expected %b", i, ready1, ready2, i == 17);
      end
    end
    m_ready = 1;
    cycle(0, '0, '0, '0, 1, 5'd0, 0);
    cycle(0, '0, '0, '0, 1, 5'd15, 0);
    cycle(0, '0, '0, '0, 1, 5'd2, 0);
    idle(4);
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d reads never returned, expected 0", q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset;
    test_byte_enable;
    test_collision;
    test_stream;
    test_drops;
    test_reinit;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_be_init.md
# sram_be_init

Parametrised single-clock dual-port block RAM with byte-enable writes, write-first collision forwarding, configurable read latency and a hardware initialisation engine that fills every word with a constant after reset or on request. It replaces fixed 16-bit × 16K packet-buffer RAMs wherever a buffer must start from a known state and software or datapath logic must not see stale contents. Read data is qualified by a valid strobe, so consumers never infer validity from timing alone.

## Interface
- DATA_W, 16, word width in bits; multiple of 8
- ADDR_W, 14, address width
- DEPTH, 2**ADDR_W, number of words; DEPTH ≤ 2**ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- INIT_VAL, 0, DATA_W-bit fill value written by the init engine
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- init_req  in  1  single-cycle pulse; restarts the fill of the whole array
- ready  out  1  high when the array is initialised and accepting accesses
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_be  in  DATA_W/8  byte enables; bit i covers din[8i+7:8i]
- din  in  DATA_W  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- dout  out  DATA_W  read data; holds its value between reads
- dout_vld  out  1  one-cycle strobe qualifying dout
- wr_drop_cnt  out  8  saturating count of ignored writes

## Operation
- FSM states: INIT, RUN.
- rst asserted: state INIT, init counter = 0, ready = 0, dout = 0, dout_vld = 0, read pipeline cleared, wr_drop_cnt = 0. Array contents are undefined until INIT completes.
- INIT: each cycle writes INIT_VAL to address init counter, increments it, and ignores user ports.
  - After writing DEPTH-1, state moves to RUN.
  - Completing the fill takes exactly DEPTH cycles.
- RUN, write: if wr_en and wr_addr < DEPTH, bytes with wr_be=1 are updated and the others are kept.
  - wr_be = 0 is a legal no-op and is not counted as a drop.
- RUN, read: if rd_en and rd_addr < DEPTH, the read is accepted.
  - rd_addr ≥ DEPTH is accepted and returns 0 with dout_vld.
- Collision (rd_addr == wr_addr, both enabled, same cycle): the returned word is write-first merged.
  - Bytes with wr_be=1 come from din; the rest come from the stored word.
  - Writes in later cycles never alter an accepted read's data.
- Dropped writes increment wr_drop_cnt, saturating at 255. A write is dropped when:
  - wr_en is high while ready = 0, or
  - wr_en is high with wr_addr ≥ DEPTH.
- Reads while ready = 0 are discarded and produce no dout_vld.
- init_req in RUN: state goes to INIT next cycle and the counter resets to 0.
  - Reads accepted before init_req still complete and return pre-init data.
  - init_req during INIT restarts the counter at 0.
  - wr_drop_cnt is not cleared by init_req.
- Simultaneous init_req with wr_en/rd_en in RUN: the access is performed (ready was 1), then INIT begins.

## Timing
- ready rises on the first rising edge at which state = RUN, i.e. DEPTH+1 cycles after the first clock edge with rst low.
- ready falls the cycle after init_req.
- RD_LAT=1: rd_en accepted at edge N → dout/dout_vld valid after edge N+1.
- RD_LAT=2: valid after edge N+2. The extra output register is in the data and vld paths only.
- Back-to-back reads give one result per cycle; no bubbles; in-order.
- dout_vld is high for exactly one cycle per accepted read. dout is unchanged when dout_vld is low.
- Write visible to a read accepted in the same cycle (forwarded) or any later cycle.
- wr_drop_cnt updates one cycle after the dropped request.

## Test plan
- Reset release, DEPTH=16, INIT_VAL=16'hA5A5:
  - ready rises 17 cycles after rst deassert.
  - Reading all 16 addresses returns 16'hA5A5 with dout_vld each cycle.
- Byte-enable write, RD_LAT=1:
  - Write addr 3 din=16'h1234 wr_be=2'b11, then din=16'hFFFF wr_be=2'b01.
  - Read addr 3 returns 16'h12FF one cycle after rd_en.
- Collision: stored 16'h1111, same-cycle write 16'hABCD wr_be=2'b10 and read of the same address → dout = 16'hAB11.
- RD_LAT=2 streaming: 8 consecutive reads of addrs 0..7 → 8 contiguous dout_vld pulses starting 2 cycles after the first rd_en, data in address order.
- Drops and re-init:
  - Writes issued during INIT, plus one write to addr ≥ DEPTH, yield wr_drop_cnt equal to their count.
  - 300 drops saturate the count at 255.
  - init_req after writing 16'h0000 to addr 5 → ready low next cycle; after re-init, addr 5 reads INIT_VAL.
- Async reset mid-INIT and mid-read: outputs zero immediately, the pending dout_vld is lost, and the fill restarts from address 0.
